// File: rtl/mux_rr_2to1.sv
// ---------------------------------------------------------------------------
// mux_rr_2to1
//
// Purpose:
//   Merges two valid/ready input lanes into one registered output stream.
//   Each lane owns a one-entry holding register; a round-robin arbiter picks
//   which held word moves into the output register. Every output word carries
//   a lane tag so a downstream 1-to-2 demux can route it back to its lane.
//
// Ports:
//   clk        in   single clock, rising-edge state updates
//   reset      in   asynchronous, active-high reset
//   data_in0   in   [BW]  lane 0 data
//   valid_in0  in         lane 0 data valid
//   ready_in0  out        lane 0 can accept this cycle (combinational)
//   data_in1   in   [BW]  lane 1 data
//   valid_in1  in         lane 1 data valid
//   ready_in1  out        lane 1 can accept this cycle (combinational)
//   data_out   out  [BW]  merged data word (registered)
//   lane_out   out        source lane of data_out (registered)
//   valid_out  out        data_out/lane_out valid (registered)
//   ready_out  in         downstream accepts this cycle
//   word_count out  [CW]  completed output handshakes, modulo 2^CW
// ---------------------------------------------------------------------------
module mux_rr_2to1 #(
  parameter int BW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [BW-1:0] data_in0,
  input  logic          valid_in0,
  output logic          ready_in0,
  input  logic [BW-1:0] data_in1,
  input  logic          valid_in1,
  output logic          ready_in1,
  output logic [BW-1:0] data_out,
  output logic          lane_out,
  output logic          valid_out,
  input  logic          ready_out,
  output logic [CW-1:0] word_count
);

  // Holding registers, one per lane
  logic [BW-1:0] hold_data0_q, hold_data0_d;
  logic          hold_valid0_q, hold_valid0_d;
  logic [BW-1:0] hold_data1_q, hold_data1_d;
  logic          hold_valid1_q, hold_valid1_d;

  // Lane granted most recently; the other lane wins the next contention
  logic          last_grant_q, last_grant_d;

  // Output register and handshake counter
  logic [BW-1:0] data_out_q, data_out_d;
  logic          lane_out_q, lane_out_d;
  logic          valid_out_q, valid_out_d;
  logic [CW-1:0] word_count_q, word_count_d;

  // Combinational control
  logic          can_load_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          accept0_s;
  logic          accept1_s;
  logic          ready_in0_s;
  logic          ready_in1_s;
  logic          out_fire_s;

  // Output register may load when it is empty or being drained this cycle
  always_comb begin
    can_load_s = !valid_out_q || ready_out;
  end

  // Round-robin arbitration between the two holding registers
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (can_load_s) begin
      case ({hold_valid1_q, hold_valid0_q})
        2'b01: begin
          grant0_s = 1'b1;
        end
        2'b10: begin
          grant1_s = 1'b1;
        end
        2'b11: begin
          // Contention: favour the lane that did not win last time
          if (last_grant_q) begin
            grant0_s = 1'b1;
          end else begin
            grant1_s = 1'b1;
          end
        end
        default: begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
      endcase
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Input readiness: a lane accepts when its hold is empty or is being
  // drained into the output register at this same edge. Grants already
  // include can_load, so this path is combinational from ready_out.
  always_comb begin
    if (reset) begin
      ready_in0_s = 1'b0;
      ready_in1_s = 1'b0;
    end else begin
      ready_in0_s = !hold_valid0_q || grant0_s;
      ready_in1_s = !hold_valid1_q || grant1_s;
    end
    accept0_s  = valid_in0 && ready_in0_s;
    accept1_s  = valid_in1 && ready_in1_s;
    out_fire_s = valid_out_q && ready_out;
  end

  // Next state of lane 0 holding register (refill wins over drain)
  always_comb begin
    hold_data0_d  = hold_data0_q;
    hold_valid0_d = hold_valid0_q;
    if (accept0_s) begin
      hold_data0_d  = data_in0;
      hold_valid0_d = 1'b1;
    end else if (grant0_s) begin
      hold_valid0_d = 1'b0;
    end else begin
      hold_valid0_d = hold_valid0_q;
    end
  end

  // Next state of lane 1 holding register (refill wins over drain)
  always_comb begin
    hold_data1_d  = hold_data1_q;
    hold_valid1_d = hold_valid1_q;
    if (accept1_s) begin
      hold_data1_d  = data_in1;
      hold_valid1_d = 1'b1;
    end else if (grant1_s) begin
      hold_valid1_d = 1'b0;
    end else begin
      hold_valid1_d = hold_valid1_q;
    end
  end

  // Next state of the output register and arbitration history
  always_comb begin
    data_out_d   = data_out_q;
    lane_out_d   = lane_out_q;
    valid_out_d  = valid_out_q;
    last_grant_d = last_grant_q;
    if (grant0_s) begin
      data_out_d   = hold_data0_q;
      lane_out_d   = 1'b0;
      valid_out_d  = 1'b1;
      last_grant_d = 1'b0;
    end else if (grant1_s) begin
      data_out_d   = hold_data1_q;
      lane_out_d   = 1'b1;
      valid_out_d  = 1'b1;
      last_grant_d = 1'b1;
    end else if (can_load_s) begin
      // Drained with nothing to replace it; data/lane keep last values
      valid_out_d  = 1'b0;
    end else begin
      // Backpressure: output register frozen
      valid_out_d  = valid_out_q;
    end
  end

  // Handshake counter, wraps naturally at 2^CW
  always_comb begin
    if (out_fire_s) begin
      word_count_d = word_count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      word_count_d = word_count_q;
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data0_q  <= {BW{1'b0}};
      hold_valid0_q <= 1'b0;
      hold_data1_q  <= {BW{1'b0}};
      hold_valid1_q <= 1'b0;
      last_grant_q  <= 1'b1;
      data_out_q    <= {BW{1'b0}};
      lane_out_q    <= 1'b0;
      valid_out_q   <= 1'b0;
      word_count_q  <= {CW{1'b0}};
    end else begin
      hold_data0_q  <= hold_data0_d;
      hold_valid0_q <= hold_valid0_d;
      hold_data1_q  <= hold_data1_d;
      hold_valid1_q <= hold_valid1_d;
      last_grant_q  <= last_grant_d;
      data_out_q    <= data_out_d;
      lane_out_q    <= lane_out_d;
      valid_out_q   <= valid_out_d;
      word_count_q  <= word_count_d;
    end
  end

  assign ready_in0  = ready_in0_s;
  assign ready_in1  = ready_in1_s;
  assign data_out   = data_out_q;
  assign lane_out   = lane_out_q;
  assign valid_out  = valid_out_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_mux_rr_2to1.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_2to1
//
// Purpose:
//   Self-checking bench for mux_rr_2to1. Stimulus tasks push the expected
//   {lane, data} words into a scoreboard queue; an independent monitor pops
//   and compares whenever the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_mux_rr_2to1;
  localparam int BW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] data_in0 = 4'h0;
  logic          valid_in0 = 1'b0;
  logic          ready_in0;
  logic [BW-1:0] data_in1 = 4'h0;
  logic          valid_in1 = 1'b0;
  logic          ready_in1;
  logic [BW-1:0] data_out;
  logic          lane_out;
  logic          valid_out;
  logic          ready_out = 1'b1;
  logic [CW-1:0] word_count;

  mux_rr_2to1 #(.BW(BW), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in0   (data_in0),
    .valid_in0  (valid_in0),
    .ready_in0  (ready_in0),
    .data_in1   (data_in1),
    .valid_in1  (valid_in1),
    .ready_in1  (ready_in1),
    .data_out   (data_out),
    .lane_out   (lane_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: expected {lane, data} in output order
  logic [BW:0]   exp_q[$];
  // Per-lane words still to be offered, and per-cycle ready_out pattern
  logic [BW-1:0] q0[$];
  logic [BW-1:0] q1[$];
  logic          rdy_q[$];

  // Monitor bookkeeping
  int            stall_cnt = 0;
  logic          stall_rdy1 = 1'b0;
  logic          prev_stall = 1'b0;
  logic [BW-1:0] prev_data = 4'h0;
  logic          prev_lane = 1'b0;
  logic [BW:0]   mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples mid-cycle, compares every output handshake
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", {31'd0, valid_out}, 32'd1);
          check("stall_word_held", {27'd0, lane_out, data_out}, {27'd0, prev_lane, prev_data});
        end
        if (valid_out && ready_out) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got lane %0d data 0x%0h, expected no word",
                     lane_out, data_out);
          end else begin
            mon_exp = exp_q.pop_front();
            check("sb_word", {27'd0, lane_out, data_out}, {27'd0, mon_exp});
          end
        end
        if (valid_out && !ready_out) begin
          stall_cnt++;
          stall_rdy1 = stall_rdy1 | ready_in1;
        end
        prev_stall = valid_out && !ready_out;
        prev_data  = data_out;
        prev_lane  = lane_out;
      end
    end
  end

  // Offer queued lane words every cycle until all are delivered
  task automatic run(input int budget, output int cycles);
    logic f0;
    logic f1;
    cycles = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && cycles < budget) begin
      valid_in0 = (q0.size() > 0);
      data_in0  = (q0.size() > 0) ? q0[0] : 4'h0;
      valid_in1 = (q1.size() > 0);
      data_in1  = (q1.size() > 0) ? q1[0] : 4'h0;
      ready_out = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
      @(negedge clk);
      f0 = valid_in0 && ready_in0;
      f1 = valid_in1 && ready_in1;
      @(posedge clk);
      #1;
      if (f0) void'(q0.pop_front());
      if (f1) void'(q1.pop_front());
      cycles++;
    end
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    ready_out = 1'b1;
    check("run_drained", q0.size() + q1.size() + exp_q.size(), 32'd0);
    q0.delete();
    q1.delete();
    exp_q.delete();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    logic [BW-1:0] w;

    // Reset state while reset is held from time zero
    #2;
    check("rst_ready_in0", {31'd0, ready_in0}, 32'd0);
    check("rst_ready_in1", {31'd0, ready_in1}, 32'd0);
    check("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("rst_word_count", {24'd0, word_count}, 32'd0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("post_rst_ready_in0", {31'd0, ready_in0}, 32'd1);
    check("post_rst_ready_in1", {31'd0, ready_in1}, 32'd1);
    check("post_rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("post_rst_data_out", {28'd0, data_out}, 32'd0);
    @(posedge clk);
    #1;

    // Single lane streaming: 1,2,3 at full rate, two cycles of latency slack
    q0 = '{4'h1, 4'h2, 4'h3};
    exp_q = '{5'h01, 5'h02, 5'h03};
    run(20, cyc);
    check("single_cycles", cyc, 32'd5);
    check("single_word_count", {24'd0, word_count}, 32'd3);

    // Contention from a fresh reset: lane 0 first, then strict alternation
    reset_pulse();
    q0 = '{4'hA, 4'hB, 4'hC, 4'hD};
    q1 = '{4'h5, 4'h6, 4'h7, 4'h8};
    exp_q = '{5'h0A, 5'h15, 5'h0B, 5'h16, 5'h0C, 5'h17, 5'h0D, 5'h18};
    run(40, cyc);
    check("contention_word_count", {24'd0, word_count}, 32'd8);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Backpressure: 0x7 stalls three cycles, lane 1 words follow in order
    stall_cnt  = 0;
    stall_rdy1 = 1'b0;
    q0 = '{4'h7};
    q1 = '{4'h1, 4'h2, 4'h3};
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_q = '{5'h07, 5'h11, 5'h12, 5'h13};
    run(40, cyc);
    check("bp_stall_cycles", stall_cnt, 32'd3);
    check("bp_ready_in1_during_stall", {31'd0, stall_rdy1}, 32'd0);
    check("bp_word_count", {24'd0, word_count}, 32'd12);

    // Reset mid-stream with both holds and output register full
    ready_out = 1'b0;
    valid_in0 = 1'b1;
    data_in0  = 4'h9;
    valid_in1 = 1'b1;
    data_in1  = 4'h4;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_pre_word", {26'd0, valid_out, lane_out, data_out}, 32'h29);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid_out", {31'd0, valid_out}, 32'd0);
    check("mid_rst_word", {27'd0, lane_out, data_out}, 32'd0);
    check("mid_rst_word_count", {24'd0, word_count}, 32'd0);
    check("mid_rst_ready_in", {30'd0, ready_in1, ready_in0}, 32'd0);
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    ready_out = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("mid_rel_ready_in", {30'd0, ready_in1, ready_in0}, 32'd3);
    check("mid_rel_valid_out", {31'd0, valid_out}, 32'd0);
    q1 = '{4'hC};
    exp_q = '{5'h1C};
    run(20, cyc);
    check("mid_first_word_cycles", cyc, 32'd3);
    check("mid_word_count", {24'd0, word_count}, 32'd1);

    // Counter wrap: 257 handshakes leave word_count at 1
    reset_pulse();
    for (int i = 0; i < 257; i++) begin
      w = 4'(i);
      q0.push_back(w);
      exp_q.push_back({1'b0, w});
    end
    run(400, cyc);
    check("wrap_cycles", cyc, 32'd259);
    check("wrap_word_count", {24'd0, word_count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
